// File: rtl/switch_debounce4.sv
// Four-channel switch conditioner: synchroniser, per-channel stability
// counter, clean levels and registered rise/fall/changed pulses.
module switch_debounce4 #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_W         = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    output logic       y_a,
    output logic       y_b,
    output logic       y_c,
    output logic       y_d,
    output logic [3:0] rise,
    output logic [3:0] fall,
    output logic       changed
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [3:0]       r_sync [SYNC_STAGES];
    logic [CNT_W-1:0] r_cnt  [4];
    logic [3:0]       r_q;
    logic [3:0]       r_rise;
    logic [3:0]       r_fall;
    logic             r_changed;

    logic [3:0]       w_s;
    logic [3:0]       w_diff;
    logic [3:0]       w_hit;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_diff = w_s ^ r_q;

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < 4; i++) begin
            w_hit[i] = w_diff[i] && (r_cnt[i] == LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= sw;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    // Counter restarts whenever the level agrees again or a change commits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!w_diff[i] || w_hit[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q       <= '0;
            r_rise    <= '0;
            r_fall    <= '0;
            r_changed <= 1'b0;
        end else begin
            r_q       <= r_q ^ w_hit;
            r_rise    <= w_hit & w_s;
            r_fall    <= w_hit & ~w_s;
            r_changed <= |w_hit;
        end
    end

    assign y_a     = r_q[0];
    assign y_b     = r_q[1];
    assign y_c     = r_q[2];
    assign y_d     = r_q[3];
    assign rise    = r_rise;
    assign fall    = r_fall;
    assign changed = r_changed;

endmodule

// File: tb/tb_switch_debounce4.sv
// Directed bench for switch_debounce4 with SYNC_STAGES=2, STABLE_CYCLES=4.
module tb_switch_debounce4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw;
    logic       y_a, y_b, y_c, y_d;
    logic [3:0] rise, fall;
    logic       changed;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    switch_debounce4 #(
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(4),
        .CNT_W        (3)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sw     (sw),
        .y_a    (y_a),
        .y_b    (y_b),
        .y_c    (y_c),
        .y_d    (y_d),
        .rise   (rise),
        .fall   (fall),
        .changed(changed)
    );

    typedef struct {
        logic       rst;
        logic [3:0] sw;
        logic [3:0] y;
        logic [3:0] r;
        logic [3:0] f;
        logic       c;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(int n, logic rst, logic [3:0] s,
                                logic [3:0] y, logic [3:0] r,
                                logic [3:0] f, logic c);
        vec_t v;
        v.rst = rst; v.sw = s; v.y = y; v.r = r; v.f = f; v.c = c;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endfunction

    task automatic step(input logic rst, input logic [3:0] s);
        rst_n = rst;
        sw    = s;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [3:0] ey,
                       input logic [3:0] er, input logic [3:0] ef,
                       input logic ec);
        logic [3:0] y;
        y = {y_d, y_c, y_b, y_a};
        total++;
        if (y !== ey || rise !== er || fall !== ef || changed !== ec) begin
            bad++;
            $display("FAIL %s: got y=%b rise=%b fall=%b chg=%b want y=%b rise=%b fall=%b chg=%b",
                     nm, y, rise, fall, changed, ey, er, ef, ec);
        end
    endtask

    initial begin
        logic [15:0] pat;
        int          npulse;
        int          first;

        rst_n = 1'b0;
        sw    = 4'h0;

        // reset, release with all switches high
        add(2, 0, 4'hF, 4'h0, 4'h0, 4'h0, 0);
        add(5, 1, 4'hF, 4'h0, 4'h0, 4'h0, 0);
        add(1, 1, 4'hF, 4'hF, 4'hF, 4'h0, 1);
        add(1, 1, 4'hF, 4'hF, 4'h0, 4'h0, 0);
        // glitch on channel 1
        add(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        add(3, 1, 4'h2, 4'h0, 4'h0, 4'h0, 0);
        add(5, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        // threshold on channel 2, both directions
        add(5, 1, 4'h4, 4'h0, 4'h0, 4'h0, 0);
        add(1, 1, 4'h4, 4'h4, 4'h4, 4'h0, 1);
        add(1, 1, 4'h4, 4'h4, 4'h0, 4'h0, 0);
        add(5, 1, 4'h0, 4'h4, 4'h0, 4'h0, 0);
        add(1, 1, 4'h0, 4'h0, 4'h0, 4'h4, 1);
        add(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].sw);
            chk($sformatf("vec%0d", i), tbl[i].y, tbl[i].r,
                tbl[i].f, tbl[i].c);
        end

        // bounce on channel 0: stable run begins at edge 6
        pat    = 16'b1111_1111_1110_1101;
        npulse = 0;
        first  = 0;
        for (int e = 1; e <= 16; e++) begin
            step(1'b1, {3'b000, pat[e-1]});
            if (rise[0]) npulse++;
            if (y_a && first == 0) first = e;
            total++;
            if (fall !== 4'h0 || rise[3:1] !== 3'b000) begin
                bad++;
                $display("FAIL bounce_side e=%0d: rise=%b fall=%b want rise=???0 fall=0000",
                         e, rise, fall);
            end
        end
        total++;
        if (first != 11) begin
            bad++;
            $display("FAIL bounce_edge: got %0d want 11", first);
        end
        total++;
        if (npulse != 1) begin
            bad++;
            $display("FAIL bounce_pulses: got %0d want 1", npulse);
        end

        // independence: channels 0 and 2 together, then channel 0 alone
        step(1'b0, 4'h0);
        chk("ind_rst", 4'h0, 4'h0, 4'h0, 0);
        for (int e = 1; e <= 5; e++) begin
            step(1'b1, 4'b0101);
            chk($sformatf("ind_wait%0d", e), 4'h0, 4'h0, 4'h0, 0);
        end
        step(1'b1, 4'b0101);
        chk("ind_rise", 4'b0101, 4'b0101, 4'h0, 1);
        step(1'b1, 4'b0101);
        chk("ind_rise_end", 4'b0101, 4'h0, 4'h0, 0);
        for (int e = 1; e <= 5; e++) begin
            step(1'b1, 4'b0100);
            chk($sformatf("ind_hold%0d", e), 4'b0101, 4'h0, 4'h0, 0);
        end
        step(1'b1, 4'b0100);
        chk("ind_fall", 4'b0100, 4'h0, 4'b0001, 1);
        step(1'b1, 4'b0100);
        chk("ind_fall_end", 4'b0100, 4'h0, 4'h0, 0);

        // reset mid-count on channel 3
        step(1'b0, 4'h0);
        chk("mid_pre", 4'h0, 4'h0, 4'h0, 0);
        for (int e = 1; e <= 3; e++) begin
            step(1'b1, 4'h8);
            chk($sformatf("mid_cnt%0d", e), 4'h0, 4'h0, 4'h0, 0);
        end
        step(1'b0, 4'h8);
        chk("mid_rst", 4'h0, 4'h0, 4'h0, 0);
        for (int e = 1; e <= 5; e++) begin
            step(1'b1, 4'h8);
            chk($sformatf("mid_wait%0d", e), 4'h0, 4'h0, 4'h0, 0);
        end
        step(1'b1, 4'h8);
        chk("mid_rise", 4'h8, 4'h8, 4'h0, 1);
        step(1'b1, 4'h8);
        chk("mid_rise_end", 4'h8, 4'h0, 4'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
